// File: rtl/systolic_output_deskew.sv
// Realigns skewed bottom-row psums of the systolic array and buffers whole rows in a FWFT FIFO.
// Build option: define DESKEW_SAT16_EN to saturate active lanes to signed 16 bits before the push.
module systolic_output_deskew #(
    parameter int N     = 2,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0][31:0]      in_data,
    input  logic [N-1:0]            in_valid,
    input  logic [15:0]             cfg_col_size,
    input  logic                    cfg_col_size_valid,
    output logic [N-1:0][31:0]      out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    err_misalign,
    output logic                    err_overflow,
    input  logic                    clr_err
);

    // Handshake: a row leaves the FIFO on a rising edge where out_valid && out_ready;
    // out_valid never looks at out_ready, and out_data holds while out_ready is low.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0][31:0] al_data;
    logic [N-1:0]       al_valid;
    logic [N-1:0]       pipe_any;
    logic [N-1:0]       act_mask;

    logic [15:0]        col_a;
    logic [15:0]        col_a_next;

    logic               all_on;
    logic               any_on;
    logic               row_push;
    logic               row_bad;
    logic [N-1:0][31:0] push_row;

    logic [N-1:0][31:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               full;
    logic               pop;
    logic               wr_en;
    logic               ovf;

`ifdef DESKEW_SAT16_EN
    function automatic logic [31:0] sat16(input logic [31:0] v);
        logic signed [31:0] s;
        s = $signed(v);
        if (s > 32'sd32767) begin
            return 32'h0000_7fff;
        end else if (s < -32'sd32768) begin
            return 32'hffff_8000;
        end else begin
            return v;
        end
    endfunction
`endif

    // Lane c: one input register plus N-1-c further stages, so every lane lands together.
    for (genvar c = 0; c < N; c++) begin : g_lane
        localparam int L = N - c;

        logic [31:0]  sd [L];
        logic [L-1:0] sv;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sv <= '0;
                for (int i = 0; i < L; i++) begin
                    sd[i] <= '0;
                end
            end else begin
                sv[0] <= in_valid[c];
                sd[0] <= in_data[c];
                for (int i = 1; i < L; i++) begin
                    sv[i] <= sv[i-1];
                    sd[i] <= sd[i-1];
                end
            end
        end

        assign al_data[c]  = sd[L-1];
        assign al_valid[c] = sv[L-1];
        assign pipe_any[c] = |sv;
        assign act_mask[c] = (col_a > 16'(c));
    end

    always_comb begin
        col_a_next = cfg_col_size;
        if (cfg_col_size == 16'd0) begin
            col_a_next = 16'd1;
        end else if (cfg_col_size > 16'(N)) begin
            col_a_next = 16'(N);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_a <= 16'(N);
        end else if (cfg_col_size_valid) begin
            col_a <= col_a_next;
        end
    end

    // Inactive lanes count as "on" for the all-set test and "off" for the any-set test.
    assign all_on   = &(al_valid | ~act_mask);
    assign any_on   = |(al_valid & act_mask);
    assign row_push = all_on;
    assign row_bad  = any_on && !all_on;

    always_comb begin
        push_row = '0;
        for (int c = 0; c < N; c++) begin
            if (act_mask[c]) begin
`ifdef DESKEW_SAT16_EN
                push_row[c] = sat16(al_data[c]);
`else
                push_row[c] = al_data[c];
`endif
            end
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign pop   = out_valid && out_ready;
    assign wr_en = row_push && (!full || pop);
    assign ovf   = row_push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_row;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign busy      = (|pipe_any) || out_valid;

    // A new error on the same edge as clr_err survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_misalign <= row_bad || (err_misalign && !clr_err);
            err_overflow <= ovf || (err_overflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew (N=4, DEPTH=4) with a queue-based row scoreboard.
module tb_systolic_output_deskew;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0][31:0] in_data;
    logic [N-1:0]       in_valid;
    logic [15:0]        cfg_col_size;
    logic               cfg_col_size_valid;
    logic [N-1:0][31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         count;
    logic               busy;
    logic               err_misalign;
    logic               err_overflow;
    logic               clr_err;

    systolic_output_deskew #(.N(N), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .cfg_col_size       (cfg_col_size),
        .cfg_col_size_valid (cfg_col_size_valid),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .count              (count),
        .busy               (busy),
        .err_misalign       (err_misalign),
        .err_overflow       (err_overflow),
        .clr_err            (clr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_q[$];

    logic [31:0] rv [8][4];
    logic        lane_en [4];
    int          lane_late [4];
    int          pulse_step;
    int          max_cnt;
    int          first_v;
    logic        rdy_base;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] mk_row(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // scoreboard monitor: a row is consumed on the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_row: got %0h expected none", out_data);
            end else begin
                check("row", out_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic stream_defaults();
        for (int c = 0; c < 4; c++) begin
            lane_en[c]   = 1'b1;
            lane_late[c] = 0;
        end
        pulse_step = -1;
    endtask

    task automatic run_stream(input int nrows, input int drain_cycles);
        int ml;
        int t_end;
        ml = 0;
        for (int c = 0; c < 4; c++) if (lane_late[c] > ml) ml = lane_late[c];
        t_end   = nrows + N - 1 + ml + drain_cycles;
        max_cnt = 0;
        first_v = -1;
        for (int t = 0; t < t_end; t++) begin
            for (int c = 0; c < N; c++) begin
                int r;
                r = t - c - lane_late[c];
                if (r >= 0 && r < nrows && lane_en[c]) begin
                    in_valid[c] = 1'b1;
                    in_data[c]  = rv[r][c];
                end else begin
                    in_valid[c] = 1'b0;
                    in_data[c]  = '0;
                end
            end
            out_ready = (t == pulse_step) ? 1'b1 : rdy_base;
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && first_v < 0) first_v = t;
        end
        in_valid  = '0;
        in_data   = '0;
        out_ready = rdy_base;
    endtask

    task automatic drain(input string name);
        rdy_base  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) step();
        check({name, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
        check({name, "_count_zero"}, 128'(count), 128'd0);
    endtask

    task automatic load_cfg(input logic [15:0] v);
        cfg_col_size       = v;
        cfg_col_size_valid = 1'b1;
        step();
        cfg_col_size_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; cfg_col_size = '0;
        cfg_col_size_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0; rdy_base = 1'b0;
        stream_defaults();
        repeat (2) step();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_err_misalign", 128'(err_misalign), 128'd0);
        check("rst_err_overflow", 128'(err_overflow), 128'd0);
        rst = 1'b0;
        step();

        // basic deskew, latency and occupancy
        rdy_base = 1'b1;
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(10 + c);
        exp_q.push_back(mk_row(10, 11, 12, 13));
        run_stream(1, 4);
        check("basic_first_valid_step", 128'(first_v), 128'd4);
        check("basic_max_count", 128'(max_cnt), 128'd1);
        check("basic_err_misalign", 128'(err_misalign), 128'd0);
        check("basic_err_overflow", 128'(err_overflow), 128'd0);
        drain("basic");
        check("basic_busy_idle", 128'(busy), 128'd0);

        // backpressure and overflow
        rdy_base = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++) rv[r][c] = 32'(r);
        for (int r = 0; r < 4; r++) exp_q.push_back(mk_row(r, r, r, r));
        run_stream(5, 2);
        check("bp_count_full", 128'(count), 128'd4);
        check("bp_err_overflow", 128'(err_overflow), 128'd1);
        check("bp_busy", 128'(busy), 128'd1);
        drain("bp");
        pulse_clr();
        check("bp_clr_overflow", 128'(err_overflow), 128'd0);

        // full FIFO with simultaneous push and pop
        rdy_base = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) rv[r][c] = 32'(20 + r);
        for (int r = 0; r < 5; r++) exp_q.push_back(mk_row(20 + r, 20 + r, 20 + r, 20 + r));
        run_stream(4, 2);
        check("full_count_before", 128'(count), 128'd4);
        for (int c = 0; c < 4; c++) rv[0][c] = 32'd24;
        pulse_step = 4;
        run_stream(1, 1);
        pulse_step = -1;
        check("full_count_after", 128'(count), 128'd4);
        check("full_err_overflow", 128'(err_overflow), 128'd0);
        drain("full");

        // misalignment: column 2 one cycle late
        rdy_base = 1'b1;
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(40 + c);
        lane_late[2] = 1;
        run_stream(1, 3);
        check("mis_err_misalign", 128'(err_misalign), 128'd1);
        check("mis_max_count", 128'(max_cnt), 128'd0);
        lane_late[2] = 0;
        pulse_clr();
        check("mis_clr", 128'(err_misalign), 128'd0);
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(50 + c);
        exp_q.push_back(mk_row(50, 51, 52, 53));
        run_stream(1, 4);
        check("mis_recover_err", 128'(err_misalign), 128'd0);
        drain("mis");

        // column size 2: inactive lanes valid with garbage, then without valid
        load_cfg(16'd2);
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(60 + c);
        exp_q.push_back(mk_row(60, 61, 0, 0));
        run_stream(1, 4);
        lane_en[2] = 1'b0; lane_en[3] = 1'b0;
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(70 + c);
        exp_q.push_back(mk_row(70, 71, 0, 0));
        run_stream(1, 4);
        check("cs2_err_misalign", 128'(err_misalign), 128'd0);
        drain("cs2");
        stream_defaults();

        // column size 0 clamps to 1
        load_cfg(16'd0);
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(80 + c);
        lane_en[2] = 1'b0;
        exp_q.push_back(mk_row(80, 0, 0, 0));
        run_stream(1, 4);
        check("cs0_err_misalign", 128'(err_misalign), 128'd0);
        drain("cs0");
        stream_defaults();

        // column size 9 clamps to 4: missing lane 3 is a misalignment
        load_cfg(16'd9);
        lane_en[3] = 1'b0;
        run_stream(1, 4);
        check("cs9_err_misalign", 128'(err_misalign), 128'd1);
        check("cs9_max_count", 128'(max_cnt), 128'd0);
        stream_defaults();
        pulse_clr();
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(85 + c);
        exp_q.push_back(mk_row(85, 86, 87, 88));
        run_stream(1, 4);
        drain("cs9");

        // reset with two rows buffered and one in flight; A must return to N
        load_cfg(16'd2);
        rdy_base = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) rv[r][c] = 32'(100 + r);
        run_stream(2, 2);
        check("rstmid_count_before", 128'(count), 128'd2);
        in_valid = 4'b0001; in_data[0] = 32'd7;
        step();
        in_valid = 4'b0011; in_data[1] = 32'd7;
        #1 rst = 1'b1;
        #1;
        check("rstmid_out_valid", 128'(out_valid), 128'd0);
        check("rstmid_count", 128'(count), 128'd0);
        check("rstmid_busy", 128'(busy), 128'd0);
        check("rstmid_out_data", out_data, 128'd0);
        in_valid = '0; in_data = '0;
        step();
        rst = 1'b0;
        repeat (8) step();
        check("rstmid_no_stale_count", 128'(count), 128'd0);
        check("rstmid_no_stale_valid", 128'(out_valid), 128'd0);
        rdy_base = 1'b1;
        for (int c = 0; c < 4; c++) rv[0][c] = 32'(110 + c);
        exp_q.push_back(mk_row(110, 111, 112, 113));
        run_stream(1, 4);
        drain("rstmid");

        // saturation build option
        rv[0][0] = 32'd70000;
        rv[0][1] = -32'sd70000;
        rv[0][2] = 32'd5;
        rv[0][3] = -32'sd5;
`ifdef DESKEW_SAT16_EN
        exp_q.push_back(mk_row(32'h0000_7fff, 32'hffff_8000, 32'd5, -32'sd5));
`else
        exp_q.push_back(mk_row(32'd70000, -32'sd70000, 32'd5, -32'sd5));
`endif
        run_stream(1, 4);
        drain("sat");

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_output_deskew.md
# systolic_output_deskew

Downstream companion to the weight-stationary systolic array. It consumes the per-column partial-sum outputs from the array's bottom row, which emerge skewed so that column c trails column 0 by c cycles. It realigns each result row, optionally saturates it, and buffers the rows in a small first-word-fall-through FIFO behind a valid/ready handshake toward the unified-buffer write path. It also flags misaligned columns and FIFO overflow.

## Interface
- `N`, 2: array width, i.e. the number of columns/lanes.
- `DEPTH`, 4: FIFO depth in rows; must be a power of 2 and ≥ 2.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_data`  in  [N-1:0][31:0] signed: bottom-row psums, skewed.
- `in_valid`  in  [N-1:0]: per-column valid, skewed with `in_data`.
- `cfg_col_size`  in  16: number of active columns.
- `cfg_col_size_valid`  in  1: load `cfg_col_size`.
- `out_data`  out  [N-1:0][31:0] signed: aligned row at the FIFO head.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts the head row.
- `count`  out  $clog2(DEPTH)+1: rows held in the FIFO.
- `busy`  out  1: any valid bit in the deskew pipeline, or FIFO not empty.
- `err_misalign`  out  1: sticky error flag.
- `err_overflow`  out  1: sticky error flag.
- `clr_err`  in  1: synchronous clear of both sticky flags.

## Operation
- **Active columns.** `A = clamp(cfg_col_size, 1, N)`, loaded on an edge where `cfg_col_size_valid` is high.
  - Reset value of A is N.
  - The loaded value takes effect from the next cycle.
  - Changing A while `busy` is high is illegal; the resulting output is unspecified but must not hang.
- **Deskew.**
  - Lane c is registered at the input, then delayed by a further N-1-c register stages (data and valid together).
  - Lane N-1 has no extra delay.
  - All lanes reach the alignment stage on the same edge.
- **Alignment check.** Per aligned cycle, consider the aligned valid bits of the active lanes 0..A-1.
  - All 0: nothing happens.
  - All 1: the row is pushed. Lanes ≥ A are forced to 0 in the pushed row.
  - Mixed: the row is dropped and `err_misalign` is set.
  - Valid bits on inactive lanes are ignored.
- **FIFO.**
  - Push an aligned row; pop when `out_valid && out_ready`.
  - Push and pop on the same edge are both performed, and `count` is unchanged. This holds when full, and succeeds even when full.
  - Push while full with no pop: the row is dropped, `err_overflow` is set, and the FIFO contents are unchanged.
  - Pop while empty cannot happen, because `out_valid` is low.
  - Read/write pointers wrap modulo DEPTH.
  - `out_data` equals the head entry and is held stable while `out_valid && !out_ready`.
- **Error flags.**
  - Flags set on the same edge as `clr_err` win: they end up set.
  - Otherwise `clr_err` clears them.
- **Reset (including mid-operation).**
  - Delay lines, alignment stage and FIFO are cleared.
  - `out_valid`=0, `out_data`=0, `count`=0, `busy`=0, both error flags 0, A=N.

## Timing
- Column 0 is sampled at edge k; column c is expected at edge k+c.
- The aligned row is registered at edge k+N-1 and written into the FIFO at edge k+N.
- If the FIFO was empty, `out_valid` is high in the cycle after edge k+N.
- Latency is therefore N+1 edges from sampling column 0.
- Throughput is one row per cycle when `out_ready` is held high; with that and a continuous input stream, the FIFO never exceeds 1 entry.
- `busy` is registered-derived: it goes low the cycle after the last row is popped and the pipeline is empty.
- All outputs are driven directly from registers or the FIFO head; there is no combinational path from `in_*` to outputs.
- `out_valid` does not depend on `out_ready`.

## Configuration
- Macro: `DESKEW_SAT16_EN`.
- Defined: each active lane is saturated to the signed 16-bit range [-32768, 32767] and sign-extended into 32 bits before the push.
  - Saturation is applied in the alignment stage.
  - Latency is unchanged.
- Undefined: the full 32-bit value passes unmodified.

## Test plan
All scenarios use N=4, DEPTH=4.

- **Basic deskew.** Column c gets valid at cycle c with data 10+c; `out_ready`=1.
  - Required: one row {13,12,11,10} (lane3..lane0), `out_valid` 5 edges after column 0 is sampled, `count` peaks at 1, no errors.
- **Backpressure and overflow.** `out_ready`=0; stream 5 consecutive skewed rows with row r data = r.
  - Required: `count`=4 holding rows 0..3; 5th row dropped; `err_overflow`=1.
  - Then `out_ready`=1: rows 0,1,2,3 come out in order.
  - Then `clr_err` clears the flag.
- **Full push+pop.** With FIFO full and `out_ready`=1 while a new row arrives.
  - Required: `count` stays 4, no overflow, order preserved.
- **Misalignment.** Column 2 valid one cycle late.
  - Required: row dropped, `err_misalign`=1, nothing pushed.
  - A following correct row is pushed normally.
- **Column size.** `cfg_col_size`=2; lanes 2,3 carry valid garbage (or no valid).
  - Required: pushed row has lanes 2,3 = 0 and no error.
  - `cfg_col_size`=0 behaves as 1; `cfg_col_size`=9 behaves as 4.
- **Reset and saturation.**
  - Assert `rst` with 2 rows buffered and 1 in flight. Required: all outputs 0 immediately; no stale row after release.
  - With `DESKEW_SAT16_EN` defined, lane value 70000 → 32767 and -70000 → -32768.
